// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int                   BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 3'd7;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stability filter; the output only
// follows the line after it has held a new value for FILTER_LEN cycles.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            cnt    <= '0;
            dout   <= 1'b1;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                dout <= sync_2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing an 8-bit register window behind an auto-incrementing
// pointer. SCL is input-only; SDA is driven open-drain through sda_oe.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR   = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr,
    output logic [7:0] reg_wdata,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_f, sda_f, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk(clk), .reset_(reset_), .din(scl_in), .dout(scl_f)
    );
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk(clk), .reset_(reset_), .din(sda_in), .dout(sda_f)
    );

    assign scl_rise  =  scl_f & ~scl_q;
    assign scl_fall  = ~scl_f &  scl_q;
    assign start_det =  scl_f &  scl_q &  sda_q & ~sda_f;
    assign stop_det  =  scl_f &  scl_q & ~sda_q &  sda_f;

    state_t               state, state_n;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [7:0]           shreg, shreg_n, byte_in;
    logic [7:0]           addr_n, wdata_n;
    logic                 sda_oe_n, busy_n, wr_n, rd_n;
    logic                 rw, rw_n, ptr_loaded, ptr_loaded_n;
    logic                 load_rd, load_rd_n;

    assign byte_in = {shreg[6:0], sda_f};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            rw         <= RW_WRITE;
            ptr_loaded <= 1'b0;
            load_rd    <= 1'b0;
            reg_addr   <= '0;
            reg_wr     <= 1'b0;
            reg_wdata  <= '0;
            reg_rd     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
            rw         <= rw_n;
            ptr_loaded <= ptr_loaded_n;
            load_rd    <= load_rd_n;
            reg_addr   <= addr_n;
            reg_wr     <= wr_n;
            reg_wdata  <= wdata_n;
            reg_rd     <= rd_n;
            scl_q      <= scl_f;
            sda_q      <= sda_f;
        end
    end

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        sda_oe_n     = sda_oe;
        busy_n       = busy;
        rw_n         = rw;
        ptr_loaded_n = ptr_loaded;
        load_rd_n    = reg_rd;
        addr_n       = reg_wr ? reg_addr + 8'd1 : reg_addr;
        wr_n         = 1'b0;
        wdata_n      = reg_wdata;
        rd_n         = 1'b0;

        if (start_det) begin
            state_n      = ADDR;
            bit_cnt_n    = '0;
            sda_oe_n     = 1'b0;
            busy_n       = 1'b0;
            ptr_loaded_n = 1'b0;
            load_rd_n    = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            load_rd_n = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_n   = byte_in;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (byte_in[7:1] == I2C_ADDR) begin
                            state_n = ADDR_ACK;
                            rw_n    = byte_in[0];
                            busy_n  = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                // The first fall starts the ACK pull-down, the second ends it.
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n = ~ACK;
                    end else begin
                        sda_oe_n = 1'b0;
                        if (state == ADDR_ACK && rw == RW_READ) begin
                            state_n = RD_BYTE;
                            rd_n    = 1'b1;
                        end else begin
                            state_n = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shreg_n   = byte_in;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = WR_ACK;
                        if (ptr_loaded) begin
                            wr_n    = 1'b1;
                            wdata_n = byte_in;
                        end else begin
                            addr_n       = byte_in;
                            ptr_loaded_n = 1'b1;
                        end
                    end
                end
                RD_BYTE: begin
                    if (load_rd) begin
                        shreg_n  = reg_rdata;
                        sda_oe_n = ~reg_rdata[7];
                    end else if (scl_fall) begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            sda_oe_n = 1'b0;
                            addr_n   = reg_addr + 8'd1;
                            state_n  = RD_ACK;
                        end else begin
                            shreg_n  = {shreg[6:0], 1'b0};
                            sda_oe_n = ~shreg[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_f == NACK) begin
                        state_n = IGNORE;
                    end else if (scl_fall) begin
                        state_n = RD_BYTE;
                        rd_n    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench: bit-bangs the I2C master side and checks the register
// window strobes, ACK behaviour, glitch rejection and reset recovery.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, reg_rd, busy;

    always #5 clk = ~clk;

    // Open-drain bus: the target can only pull the line low.
    assign sda_line  = m_sda & ~sda_oe;
    assign reg_rdata = ~reg_addr;

    i2c_target #(.I2C_ADDR(7'h42), .FILTER_LEN(3)) dut (
        .clk(clk), .reset_(reset_), .scl_in(m_scl), .sda_in(sda_line),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wr(reg_wr),
        .reg_wdata(reg_wdata), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
        .busy(busy)
    );

    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];
    logic [7:0] rd_a[$];
    logic       oe_seen, busy_seen;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_a.push_back(reg_addr);
            wr_d.push_back(reg_wdata);
        end
        if (reg_rd) rd_a.push_back(reg_addr);
        if (sda_oe) oe_seen = 1'b1;
        if (busy)   busy_seen = 1'b1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        rd_a.delete();
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic q();
        repeat (10) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        m_sda = 1'b0; q();
        m_scl = 1'b0; q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; q();
        m_scl = 1'b1; q();
        m_sda = 1'b1; q();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; q();
        m_scl = 1'b1; q(); q();
        m_scl = 1'b0; q();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        b = sda_line; q();
        m_scl = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(master_ack);
    endtask

    task automatic glitch(input int n);
        m_sda = 1'b0;
        repeat (n) @(negedge clk);
        m_sda = 1'b1;
    endtask

    logic       a0, a1, a2, a3, b;
    logic [7:0] d0, d1;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_strobes", {reg_wr, reg_rd}, 2'b00);
        reset_ = 1'b1;
        q();

        // Write: pointer 0x10, data 0xAB, 0xCD
        clear_logs();
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'h10, a1);
        write_byte(8'hAB, a2);
        write_byte(8'hCD, a3);
        check("wr_acks", {a0, a1, a2, a3}, 4'b0000);
        check("wr_busy_on", busy, 1);
        bus_stop();
        check("wr_busy_off", busy, 0);
        check("wr_count", wr_a.size(), 2);
        check("wr0_addr", wr_a[0], 8'h10);
        check("wr0_data", wr_d[0], 8'hAB);
        check("wr1_addr", wr_a[1], 8'h11);
        check("wr1_data", wr_d[1], 8'hCD);
        check("wr_final_ptr", reg_addr, 8'h12);

        // Combined read: pointer 0x20, repeated start, two bytes
        clear_logs();
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'h20, a1);
        bus_start();
        write_byte(8'h85, a2);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        check("rd_acks", {a0, a1, a2}, 3'b000);
        check("rd_byte0", d0, 8'hDF);
        check("rd_byte1", d1, 8'hDE);
        check("rd_oe_after_nack", sda_oe, 0);
        bus_stop();
        check("rd_count", rd_a.size(), 2);
        check("rd0_addr", rd_a[0], 8'h20);
        check("rd1_addr", rd_a[1], 8'h21);
        check("rd_final_ptr", reg_addr, 8'h22);
        check("rd_no_writes", wr_a.size(), 0);

        // Address mismatch
        clear_logs();
        bus_start();
        write_byte(8'h86, a0);
        write_byte(8'h10, a1);
        write_byte(8'h55, a2);
        bus_stop();
        check("nm_addr_nack", a0, 1);
        check("nm_oe_seen", oe_seen, 0);
        check("nm_wr_count", wr_a.size(), 0);
        check("nm_busy_seen", busy_seen, 0);

        // Glitches inside the first data bit (SCL high, SDA high)
        clear_logs();
        bus_start();
        write_byte(8'h84, a0);
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        glitch(1); q();
        glitch(2); q();
        check("gl_busy_kept", busy, 1);
        m_scl = 1'b0; q();
        for (int i = 6; i >= 0; i--) write_bit(i == 0);
        read_bit(a1);
        write_byte(8'h5A, a2);
        check("gl_acks", {a0, a1, a2}, 3'b000);
        check("gl_wr_count", wr_a.size(), 1);
        check("gl_wr_addr", wr_a[0], 8'h81);
        check("gl_wr_data", wr_d[0], 8'h5A);
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        glitch(3); q();
        check("gl_pulse_detected", busy, 0);
        check("gl_ptr", reg_addr, 8'h82);

        // Pointer wrap
        clear_logs();
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        bus_stop();
        check("wrap_acks", {a0, a1, a2, a3}, 4'b0000);
        check("wrap_count", wr_a.size(), 2);
        check("wrap0", {wr_a[0], wr_d[0]}, 16'hFF11);
        check("wrap1", {wr_a[1], wr_d[1]}, 16'h0022);
        check("wrap_ptr", reg_addr, 8'h01);

        // Reset in the middle of a read while the target pulls SDA low
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'h80, a1);
        bus_stop();
        bus_start();
        write_byte(8'h85, a2);
        check("mr_oe_driving", sda_oe, 1);
        reset_ = 1'b0;
        #1;
        check("mr_oe_released", sda_oe, 0);
        @(negedge clk);
        clear_logs();
        reset_ = 1'b1;
        for (int i = 0; i < 9; i++) read_bit(b);
        bus_stop();
        check("mr_no_strobes", wr_a.size() + rd_a.size(), 0);
        check("mr_ptr_cleared", reg_addr, 8'h00);
        bus_start();
        write_byte(8'h85, a0);
        read_byte(1'b1, d0);
        bus_stop();
        check("mr_new_ack", a0, 0);
        check("mr_new_data", d0, 8'hFF);
        check("mr_new_rd", {rd_a.size() == 1, rd_a[0]}, {1'b1, 8'h00});
        check("mr_new_ptr", reg_addr, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
